// File: rtl/sfifo_pkg.sv
// Shared constants and width helpers for the parameterised synchronous FIFO.
// Imported by the storage array and the control block.
package sfifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage: one write port and one registered read port.
// The array itself is never reset; only the read register is.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Holds the last read value whenever no read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sfifo_param.sv
// Synchronous FIFO control: pointers, occupancy counter, status flags
// and one-cycle overflow/underflow pulses around the sfifo_mem array.
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_enable,
  input  logic                      read_enable,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sfifo_param: DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sfifo_param: DATA_WIDTH must be >= 1");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sfifo_param: AFULL_THRESH out of range");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
    $error("sfifo_param: AEMPTY_THRESH out of range");
  end

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          valid_d, valid_q;
  logic          ovf_d, ovf_q;
  logic          udf_d, udf_q;
  logic          rd_acc;
  logic          wr_acc;

  // A full FIFO still takes a write when a read frees the slot this cycle.
  assign rd_acc = read_enable && !empty;
  assign wr_acc = write_enable && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_acc;
    ovf_d    = write_enable && !wr_acc;
    udf_d    = read_enable && !rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign count        = count_q;
  assign data_valid   = valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sfifo_param.md
SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count (power of two, >=2).
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, meaning almost_full asserts when count >= value.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, meaning almost_empty asserts when count <= value.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge triggered.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port write_enable, input, 1, meaning write request this cycle.
REQ-008 SHALL have port read_enable, input, 1, meaning read request this cycle.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, meaning write data, sampled with write_enable.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, meaning registered read data.
REQ-011 SHALL have port data_valid, output, 1, meaning data_out was loaded by a read accepted on the previous edge.
REQ-012 SHALL have port full, empty, almost_full, almost_empty, output, 1 each, meaning the status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, meaning current occupancy 0..DEPTH.
REQ-014 SHALL have port overflow, underflow, output, 1 each, meaning one-cycle pulses on a rejected write/read.

Function
REQ-015 Write accepted SHALL be write_enable && (!full || read accepted same cycle); the entry is stored at write pointer and the pointer advances by 1 mod DEPTH.
REQ-016 Read accepted SHALL be read_enable && !empty; the head entry is loaded into data_out on that edge and read pointer advances mod DEPTH.
REQ-017 Read latency SHALL be 1 cycle: data_out/data_valid change at the accepting edge; data_out holds its value when no read is accepted; data_valid is 0 otherwise.
REQ-018 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-019 Full and both enables: both SHALL be accepted, full stays 1, overflow stays 0.
REQ-020 Empty and both enables: write accepted, read rejected, underflow pulses 1, no fall-through (data_out unchanged).
REQ-021 Rejected write SHALL not modify memory, pointers or count; overflow pulses high for exactly that cycle after the edge.
REQ-022 Rejected read SHALL not modify pointers, count or data_out; underflow pulses high for exactly that cycle after the edge.
REQ-023 count SHALL be a registered occupancy counter; full = (count==DEPTH), empty = (count==0), almost flags compare count to thresholds; all flags derive from registered state only.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.

Reset
REQ-025 On reset low, asynchronously: pointers=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-026 Memory contents SHALL not be reset; reset mid-operation discards all stored entries.
REQ-027 Release of reset SHALL take effect on the next rising edge; requests in the release cycle are honoured normally.

Structure
REQ-028 Package sfifo_pkg SHALL hold default DATA_WIDTH/DEPTH constants and the pointer/count width computation.
REQ-029 Storage SHALL be a sub-module sfifo_mem: 1 write port, 1 synchronous read port, DEPTH x DATA_WIDTH register array; control/flags stay in sfifo_param.
REQ-030 Parameter legality (DEPTH power of two, thresholds in 0..DEPTH) SHALL be checked at elaboration.

Verification (defaults unless stated)
REQ-031 Reset, write 8 entries 1,9,7,3,4,6,8,10 -> count=8, full=1 after 8th edge, almost_full=1 from count=6, overflow=0.
REQ-032 Full, write 0x17 only -> overflow pulses 1 cycle, count stays 8; then 8 reads -> data_out 1,9,7,3,4,6,8,10 each 1 cycle after accept, data_valid=1, empty=1 at end.
REQ-033 Empty, read only -> underflow 1 cycle, data_valid=0, data_out unchanged.
REQ-034 Count=4, read+write 20 cycles -> count stays 4, output order preserved across pointer wrap.
REQ-035 Full, read+write same cycle -> both accepted, full stays 1, no overflow; empty, read+write -> count=1, underflow=1.
REQ-036 Assert reset low mid-stream (count=5, asynchronous, between edges) -> all outputs at reset values immediately; after release, first read returns first post-reset write.
